// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: each channel has its own synchroniser, settle counter
// and four-state FSM, and produces a stable level, rise/fall pulses and a busy flag.
module debouncer_multi #(
    parameter int                  CHANNELS        = 4,
    parameter int                  DEBOUNCE_CYCLES = 2_000_000,
    parameter int                  SYNC_STAGES     = 2,
    parameter logic [CHANNELS-1:0] RESET_LEVEL     = '0,
    parameter int                  CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync;
            logic                   s;
            state_t                 state;
            logic [CNT_WIDTH-1:0]   cnt;
            logic                   deb_r;
            logic                   rise_r;
            logic                   fall_r;

            assign s = sync[SYNC_STAGES-1];

            // Any disagreement with s in a WAIT state sends the channel straight
            // back to its old stable state, so the wait always restarts from zero.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync   <= {SYNC_STAGES{RESET_LEVEL[i]}};
                    state  <= RESET_LEVEL[i] ? STABLE_HIGH : STABLE_LOW;
                    cnt    <= '0;
                    deb_r  <= RESET_LEVEL[i];
                    rise_r <= 1'b0;
                    fall_r <= 1'b0;
                end else begin
                    sync   <= {sync[SYNC_STAGES-2:0], noisy[i]};
                    rise_r <= 1'b0;
                    fall_r <= 1'b0;
                    case (state)
                        STABLE_LOW: begin
                            if (s) begin
                                state <= WAIT_HIGH;
                                cnt   <= '0;
                            end
                        end
                        WAIT_HIGH: begin
                            if (!s) begin
                                state <= STABLE_LOW;
                                cnt   <= '0;
                            end else if (cnt == TERMINAL) begin
                                state  <= STABLE_HIGH;
                                cnt    <= '0;
                                deb_r  <= 1'b1;
                                rise_r <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        STABLE_HIGH: begin
                            if (!s) begin
                                state <= WAIT_LOW;
                                cnt   <= '0;
                            end
                        end
                        WAIT_LOW: begin
                            if (s) begin
                                state <= STABLE_HIGH;
                                cnt   <= '0;
                            end else if (cnt == TERMINAL) begin
                                state  <= STABLE_LOW;
                                cnt    <= '0;
                                deb_r  <= 1'b0;
                                fall_r <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= STABLE_LOW;
                            cnt   <= '0;
                        end
                    endcase
                end
            end

            assign debounced[i] = deb_r;
            assign rise[i]      = rise_r;
            assign fall[i]      = fall_r;
            assign busy[i]      = (state == WAIT_HIGH) || (state == WAIT_LOW);
        end
    endgenerate

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
Multi-channel, parametrised debouncer for buttons and switches. Each channel has its own synchroniser, settle counter and 4-state FSM. Besides the stable level, each channel gives single-cycle rise/fall pulses and a busy flag, so downstream logic needs no edge detector. It sits between board-level pins and control FSMs.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
DEBOUNCE_CYCLES, 2_000_000, clk cycles the synchronised input must stay at the new level before it is accepted (>=2; 20 ms at 100 MHz)
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
RESET_LEVEL, {CHANNELS{1'b0}}, per-channel level loaded into synchroniser, FSM and debounced output on reset
CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), settle-counter width (derived; do not override)

Ports:
clk        input   1         system clock; all state updates on its rising edge
reset      input   1         asynchronous, active-high reset
noisy      input   CHANNELS  raw asynchronous inputs, one bit per channel
debounced  output  CHANNELS  accepted stable level per channel (registered)
rise       output  CHANNELS  one-cycle pulse when debounced goes 0->1
fall       output  CHANNELS  one-cycle pulse when debounced goes 1->0
busy       output  CHANNELS  1 while the channel is in a WAIT state

Behaviour:
- Reset: clk and reset are fixed as one clock plus asynchronous, active-high reset.
- On reset, for each channel i: all synchroniser flops = RESET_LEVEL[i]; FSM = STABLE_HIGH if RESET_LEVEL[i] else STABLE_LOW; counter = 0; debounced[i] = RESET_LEVEL[i]; rise = fall = busy = 0.
- No pulses are generated on reset release.
- Synchroniser: a SYNC_STAGES-deep shift register; s = last stage. Nothing else samples noisy directly.
- Per-channel FSM states:
  - STABLE_LOW: if s=1, go to WAIT_HIGH and set cnt=0.
  - WAIT_HIGH: if s=0, go to STABLE_LOW and set cnt=0 (glitch rejected; no output change). Else if cnt==DEBOUNCE_CYCLES-1, go to STABLE_HIGH. Else cnt+1.
  - STABLE_HIGH: if s=0, go to WAIT_LOW and set cnt=0.
  - WAIT_LOW: mirror of WAIT_HIGH. s=1 returns to STABLE_HIGH; terminal count goes to STABLE_LOW.
- debounced: 1 in STABLE_HIGH and WAIT_LOW, 0 otherwise. It is registered and changes only on WAIT->opposite-STABLE transitions.
- rise/fall: registered. Asserted exactly in the cycle debounced first shows the new value, for 1 cycle only.
- busy: 1 exactly while the state is WAIT_HIGH or WAIT_LOW.
- Latency: a clean step on noisy sampled at edge E0 gives a debounced change after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES, i.e. SYNC_STAGES+DEBOUNCE_CYCLES+1 edges counted from E0. The input must stay stable throughout.
- Any bounce, even one cycle, during WAIT restarts the full wait from the next clean edge. There is no partial credit.
- The counter never wraps: it is compared at DEBOUNCE_CYCLES-1 and cleared on every state entry.
- Channels are fully independent. Simultaneous events on several channels are handled in parallel with identical per-channel timing.
- Asynchronous reset mid-WAIT aborts immediately: outputs return to RESET_LEVEL values on the reset edge with no pulse.
- No combinational path from noisy to any output.

Test Plan:
Use CHANNELS=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=4'b0000 unless stated.
- Clean rise: noisy[0] 0->1 before edge E0, then held -> debounced[0]=1 and rise[0]=1 after edge E0+6, rise[0]=0 after E0+7; busy[0]=1 during the 4 wait cycles; other channels stay 0.
- Bounce rejection: noisy[1] toggles 1,0,1,0,1 with 1-cycle periods, then holds 1 -> no rise or debounced change during the bounce; debounced[1]=1 exactly 6 edges after the final 0->1 edge.
- Short pulse: noisy[2]=1 for 3 cycles, then 0 -> debounced[2], rise[2] and fall[2] stay 0 throughout; busy[2] pulses then returns to 0.
- Fall and simultaneous channels: all four channels debounced high; noisy=4'b0000 at the same edge -> fall=4'b1111 for exactly one cycle and debounced=0000 after that edge, on the same cycle for all channels.
- Reset mid-wait: assert reset while channel 3 is in WAIT_HIGH with cnt=2 -> debounced[3]=0 and busy[3]=0 immediately, no rise; after release, holding noisy[3]=1 gives the full 6-edge latency.
- RESET_LEVEL=4'b1111 with noisy held high through reset release -> debounced=1111 from reset; no rise or fall pulses ever appear.
